// File: rtl/contador_bcd_varredura.sv
// N-digit BCD up/down counter that time-multiplexes its digits onto one shared 4-bit bus (A..D) plus an active-low digit select.
// Latency: valor/carry one cycle after load/en; A..D and dig_sel one cycle after an index or valor change. No backpressure.
// Optional build macro SUPRIME_ZEROS_EN enables leading-zero blanking of dig_sel.
module contador_bcd_varredura #(
    parameter int N_DIGITOS = 4,
    parameter int DIV_VARR  = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   up,
    input  logic                   load,
    input  logic [4*N_DIGITOS-1:0] load_val,
    output logic                   A,
    output logic                   B,
    output logic                   C,
    output logic                   D,
    output logic [N_DIGITOS-1:0]   dig_sel,
    output logic                   carry,
    output logic [4*N_DIGITOS-1:0] valor
);

    localparam int IDX_W = (N_DIGITOS > 1) ? $clog2(N_DIGITOS) : 1;
    localparam int PRE_W = $clog2(DIV_VARR);
    localparam logic [IDX_W-1:0]     IDX_ULT = IDX_W'(N_DIGITOS - 1);
    localparam logic [PRE_W-1:0]     PRE_ULT = PRE_W'(DIV_VARR - 1);
    localparam logic [N_DIGITOS-1:0] SEL_RST = ~(N_DIGITOS'(1));

    logic [4*N_DIGITOS-1:0] valor_q, valor_d;
    logic                   carry_q, carry_d;
    logic [PRE_W-1:0]       presc_q, presc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [3:0]             bcd_q, bcd_d;
    logic [N_DIGITOS-1:0]   dig_sel_q, dig_sel_d;

    logic [3:0] nib;
    logic       ripple;

    // Counter: load clamps each nibble to 9; a count ripples from digit 0 upward
    always_comb begin
        valor_d = valor_q;
        carry_d = 1'b0;
        nib     = 4'd0;
        ripple  = 1'b0;
        if (load) begin
            for (int i = 0; i < N_DIGITOS; i++) begin
                nib = load_val[4*i +: 4];
                valor_d[4*i +: 4] = (nib > 4'd9) ? 4'd9 : nib;
            end
        end else if (en) begin
            ripple = 1'b1;
            for (int i = 0; i < N_DIGITOS; i++) begin
                nib = valor_q[4*i +: 4];
                if (ripple) begin
                    if (up) begin
                        if (nib == 4'd9) begin
                            nib = 4'd0;
                        end else begin
                            nib    = nib + 4'd1;
                            ripple = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            nib = 4'd9;
                        end else begin
                            nib    = nib - 4'd1;
                            ripple = 1'b0;
                        end
                    end
                end
                valor_d[4*i +: 4] = nib;
            end
            // Ripple still set past the top digit means the whole counter wrapped
            carry_d = ripple;
        end
    end

    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        idx_d   = idx_q;
        if (presc_q == PRE_ULT) begin
            presc_d = '0;
            idx_d   = (idx_q == IDX_ULT) ? '0 : idx_q + IDX_W'(1);
        end
    end

`ifdef SUPRIME_ZEROS_EN
    // zero_acima[i]: digit i and every more-significant digit are zero
    logic [N_DIGITOS-1:0] zero_acima;
    always_comb begin
        zero_acima = '0;
        zero_acima[N_DIGITOS-1] = (valor_q[4*N_DIGITOS-1 -: 4] == 4'd0);
        for (int i = N_DIGITOS - 2; i >= 0; i--) begin
            zero_acima[i] = (valor_q[4*i +: 4] == 4'd0) && zero_acima[i+1];
        end
    end
`endif

    always_comb begin
        bcd_d     = 4'd0;
        dig_sel_d = '1;
        for (int i = 0; i < N_DIGITOS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                bcd_d        = valor_q[4*i +: 4];
                dig_sel_d[i] = 1'b0;
`ifdef SUPRIME_ZEROS_EN
                if ((i != 0) && zero_acima[i]) begin
                    dig_sel_d = '1;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valor_q   <= '0;
            carry_q   <= 1'b0;
            presc_q   <= '0;
            idx_q     <= '0;
            bcd_q     <= 4'd0;
            dig_sel_q <= SEL_RST;
        end else begin
            valor_q   <= valor_d;
            carry_q   <= carry_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            bcd_q     <= bcd_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    assign {A, B, C, D} = bcd_q;
    assign dig_sel      = dig_sel_q;
    assign carry        = carry_q;
    assign valor        = valor_q;

endmodule

// File: tb/tb_contador_bcd_varredura.sv
// Directed bench for contador_bcd_varredura with N_DIGITOS=4, DIV_VARR=4.
// Optional macro SUPRIME_ZEROS_EN selects the blanking expectations.
module tb_contador_bcd_varredura;

    logic        clk;
    logic        reset;
    logic        en;
    logic        up;
    logic        load;
    logic [15:0] load_val;
    logic        A, B, C, D;
    logic [3:0]  dig_sel;
    logic        carry;
    logic [15:0] valor;

    int total = 0;
    int bad   = 0;

    contador_bcd_varredura #(
        .N_DIGITOS(4),
        .DIV_VARR (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .load    (load),
        .load_val(load_val),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .dig_sel (dig_sel),
        .carry   (carry),
        .valor   (valor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       nome;
        logic        rst;
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic [15:0] exp_valor;
        logic        exp_carry;
    } vec_t;

    vec_t tab[14];

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nome, got, exp);
        end
    endtask

    // Release reset together with a load, then follow the scan for n cycles
    task automatic scan_check(input string nome, input logic [15:0] v, input int n);
        logic [3:0] exp_sel;
        logic [3:0] exp_bcd;
        logic [15:0] vs;
        int idx;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        load     = 1'b1;
        load_val = v;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            load = 1'b0;
            if (k >= 2) begin
                idx     = ((k - 1) / 4) % 4;
                vs      = v >> (4 * idx);
                exp_bcd = vs[3:0];
                exp_sel = ~(4'b0001 << idx);
`ifdef SUPRIME_ZEROS_EN
                if (idx != 0 && (v >> (4 * idx)) == 16'h0) exp_sel = 4'b1111;
`endif
                chk({nome, "_sel"}, {28'h0, dig_sel}, {28'h0, exp_sel});
                chk({nome, "_bcd"}, {28'h0, A, B, C, D}, {28'h0, exp_bcd});
            end
        end
    endtask

    initial begin
        tab[0]  = '{"ld0199",   0, 1, 16'h0199, 0, 0, 16'h0199, 0};
        tab[1]  = '{"ripple",   0, 0, 16'h0000, 1, 1, 16'h0200, 0};
        tab[2]  = '{"ld9999",   0, 1, 16'h9999, 0, 0, 16'h9999, 0};
        tab[3]  = '{"wrap_up",  0, 0, 16'h0000, 1, 1, 16'h0000, 1};
        tab[4]  = '{"carry_off",0, 0, 16'h0000, 0, 0, 16'h0000, 0};
        tab[5]  = '{"wrap_dn",  0, 0, 16'h0000, 1, 0, 16'h9999, 1};
        tab[6]  = '{"rst_pri",  1, 1, 16'h1234, 1, 1, 16'h0000, 0};
        tab[7]  = '{"clamp",    0, 1, 16'hAF3C, 1, 1, 16'h9939, 0};
        tab[8]  = '{"inc_9939", 0, 0, 16'h0000, 1, 1, 16'h9940, 0};
        tab[9]  = '{"ld0090",   0, 1, 16'h0090, 0, 0, 16'h0090, 0};
        tab[10] = '{"dec_0090", 0, 0, 16'h0000, 1, 0, 16'h0089, 0};
        tab[11] = '{"ld0000",   0, 1, 16'h0000, 0, 1, 16'h0000, 0};
        tab[12] = '{"wrap_dn2", 0, 0, 16'h0000, 1, 0, 16'h9999, 1};
        tab[13] = '{"idle",     0, 0, 16'h0000, 0, 0, 16'h9999, 0};

        reset    = 1'b1;
        en       = 1'b0;
        up       = 1'b0;
        load     = 1'b0;
        load_val = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valor", {16'h0, valor}, 32'h0);
        chk("rst_sel",   {28'h0, dig_sel}, 32'hE);
        chk("rst_bcd",   {28'h0, A, B, C, D}, 32'h0);
        chk("rst_carry", {31'h0, carry}, 32'h0);

        scan_check("scan1234", 16'h1234, 33);
        scan_check("blank0040", 16'h0040, 17);

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            reset    = tab[i].rst;
            load     = tab[i].ld;
            load_val = tab[i].lv;
            en       = tab[i].en;
            up       = tab[i].up;
            @(posedge clk);
            #1;
            chk({tab[i].nome, "_valor"}, {16'h0, valor}, {16'h0, tab[i].exp_valor});
            chk({tab[i].nome, "_carry"}, {31'h0, carry}, {31'h0, tab[i].exp_carry});
        end

        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        en    = 1'b0;
        up    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("hold_valor", {16'h0, valor}, 32'h9999);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/contador_bcd_varredura.md
Name: contador_bcd_varredura

Overview:
- Upstream stage of the 7-segment decoder.
- Holds an N-digit BCD up/down counter and time-multiplexes its digits onto one shared 4-bit BCD bus (A..D, A = MSB) plus an active-low digit-select vector.
- The decoder consumes A..D combinationally; dig_sel drives the display common pins.

Parameters:
- N_DIGITOS, 4, number of BCD digits (1..8).
- DIV_VARR, 50000, clock cycles each digit stays selected (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count strobe; one step per cycle in which it is high.
- up  input  1  1 = increment, 0 = decrement; sampled with en.
- load  input  1  synchronous load of load_val.
- load_val  input  4*N_DIGITOS  BCD value to load; digit 0 in bits [3:0].
- A, B, C, D  output  1 each  BCD of the currently scanned digit (A = bit 3, D = bit 0).
- dig_sel  output  N_DIGITOS  active-low one-hot digit enable.
- carry  output  1  one-cycle pulse on wrap (overflow up or borrow down).
- valor  output  4*N_DIGITOS  full registered counter value.

Behaviour:
- Interface clocking: one clock, clk. Reset is synchronous and active-high on reset. Every state element updates only on the rising edge of clk.
- Reset values:
  - valor = 0, carry = 0.
  - Scan index = 0, prescaler = 0.
  - dig_sel = all ones except bit 0 low.
  - A..D = 0000.
- Reset mid-operation discards any pending load, en or scan phase.
- Counter priority: reset > load > en.
- load:
  - valor <= load_val; carry = 0.
  - Any nibble > 9 is loaded as 9 (per digit, independently).
- en with up = 1:
  - BCD increment with ripple; a digit at 9 goes to 0 and increments the next digit.
  - All-9s -> all-0s, with carry = 1 on the following cycle only.
- en with up = 0:
  - BCD decrement; a digit at 0 goes to 9 and borrows from the next digit.
  - All-0s -> all-9s, with carry = 1 for one cycle.
- carry is registered and is 0 in every cycle that does not follow a wrap.
- Latency: valor reflects load/en one cycle after the edge on which it is sampled.
- Scan prescaler:
  - Counts 0..DIV_VARR-1. On terminal count it returns to 0 and the scan index advances.
  - Index sequence: 0, 1, ..., N_DIGITOS-1, then wraps to 0.
- Output registers:
  - {A,B,C,D} and dig_sel are registered from the index value and valor.
  - They update one cycle after an index change or a valor change, so a displayed digit follows a count within one cycle even mid-slot.
- Exactly one dig_sel bit is low at all times, except when blanking is active (see Optional Feature).
- Prescaler and scan are free-running and independent of en, load and up.

Optional Feature:
- Macro: SUPRIME_ZEROS_EN.
- Defined (leading-zero blanking):
  - When the scanned digit is 0 and every more-significant digit is 0, dig_sel is all ones for that slot.
  - Digit 0 is never blanked, so value 0 shows a single "0".
  - A..D still present 0000.
- Not defined: every digit is always enabled during its slot.

Test Plan:
- Reset behaviour: N_DIGITOS=4, DIV_VARR=4; assert reset 3 cycles -> valor=0x0000, dig_sel=1110, A..D=0000, carry=0.
- Ripple increment: load_val=0x0199, then en=1, up=1 for 1 cycle -> valor=0x0200, carry=0.
- Wrap up: from 0x9999, en=1, up=1 -> valor=0x0000, carry=1 for exactly one cycle.
- Wrap down and hold: from 0x0000, en=1, up=0 -> valor=0x9999, carry pulse. With en=0 for 10 cycles -> valor holds.
- Clamp and priority: load_val=0xAF3C with load=1 and en=1 in the same cycle -> valor=0x9939, no count applied.
- Scan timing: valor=0x1234, DIV_VARR=4 -> sequence dig_sel=1110/A..D=0100, 1101/0011, 1011/0010, 0111/0001, each held 4 cycles, then repeats.
- Blanking (SUPRIME_ZEROS_EN): valor=0x0040 -> digit 3 and digit 2 slots have dig_sel=1111; digit 1 shows 4 and digit 0 shows 0. Without the macro, all four slots are enabled.
